// File: rtl/downsample_2d_if.sv
// Pixel stream bundle for downsample_2d: input stream and output stream with valid/ready handshakes.
interface downsample_2d_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned CH = 3
);
    localparam int unsigned PW = CH * DW;

    logic          i_valid;
    logic          i_ready;
    logic [PW-1:0] i_data;
    logic          o_valid;
    logic          o_ready;
    logic [PW-1:0] o_data;
    logic          o_last;

    modport slave (
        input  i_valid, i_data, o_ready,
        output i_ready, o_valid, o_data, o_last
    );

    modport master (
        output i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_data, o_last
    );
endinterface

// File: rtl/downsample_2d.sv
// Raster-order 2D downsampler: decimates or box-averages FxF pixel blocks (F = 1, 2, 4)
// and emits one pixel per complete block through a single output register.
module downsample_2d #(
    parameter int unsigned DW    = 8,
    parameter int unsigned CH    = 3,
    parameter int unsigned MAX_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(MAX_W):0]   cfg_w,
    input  logic [15:0]              cfg_h,
    input  logic [1:0]               cfg_shift,
    input  logic                     cfg_avg,
    downsample_2d_if.slave           bus
);
    localparam int unsigned XW  = $clog2(MAX_W) + 1;
    localparam int unsigned AIW = $clog2(MAX_W);
    localparam int unsigned PW  = CH * DW;
    localparam int unsigned AW  = DW + 4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          r_state, w_state_nxt;
    logic [XW-1:0]   r_x, w_x_nxt, r_w;
    logic [15:0]     r_y, w_y_nxt, r_h;
    logic [1:0]      r_s;
    logic            r_avg;
    logic            w_latch;

    logic            r_o_valid, r_o_last;
    logic [PW-1:0]   r_o_data;

    logic [XW-1:0]   w_w, w_bx, w_nbx;
    logic [15:0]     w_h, w_by, w_nby;
    logic [1:0]      w_s, w_mask, w_lx, w_ly;
    logic            w_avg, w_beat, w_first, w_lastpx, w_complete, w_final_blk, w_emit;
    logic            w_end_x, w_end_y;
    logic [AW-1:0]   w_rnd;
    logic [CH*AW-1:0] w_acc_rd, w_acc_wr;
    logic [PW-1:0]   w_avg_px;

    logic [CH*AW-1:0] r_acc [MAX_W];

    assign bus.i_ready = !r_o_valid || bus.o_ready;
    assign bus.o_valid = r_o_valid;
    assign bus.o_data  = r_o_data;
    assign bus.o_last  = r_o_last;

    assign w_beat = bus.i_valid && bus.i_ready;

    // Config is live from the ports in IDLE and frozen once a frame has started.
    always_comb begin
        w_w   = (r_state == IDLE) ? cfg_w   : r_w;
        w_h   = (r_state == IDLE) ? cfg_h   : r_h;
        w_avg = (r_state == IDLE) ? cfg_avg : r_avg;
        if (r_state == IDLE) w_s = (cfg_shift == 2'd3) ? 2'd2 : cfg_shift;
        else                 w_s = r_s;
    end

    // Block geometry of the current raster position.
    always_comb begin
        w_mask      = (w_s == 2'd0) ? 2'b00 : ((w_s == 2'd1) ? 2'b01 : 2'b11);
        w_lx        = 2'(r_x) & w_mask;
        w_ly        = 2'(r_y) & w_mask;
        w_first     = (w_lx == 2'b00) && (w_ly == 2'b00);
        w_lastpx    = (w_lx == w_mask) && (w_ly == w_mask);
        w_bx        = r_x >> w_s;
        w_by        = r_y >> w_s;
        w_nbx       = w_w >> w_s;
        w_nby       = w_h >> w_s;
        w_complete  = (w_bx < w_nbx) && (w_by < w_nby);
        w_final_blk = (w_bx == XW'(w_nbx - XW'(1))) && (w_by == 16'(w_nby - 16'd1));
        w_emit      = w_complete && (w_avg ? w_lastpx : w_first);
        w_end_x     = (r_x == XW'(w_w - XW'(1)));
        w_end_y     = (r_y == 16'(w_h - 16'd1));
        w_rnd       = (w_s == 2'd0) ? AW'(0) : ((w_s == 2'd1) ? AW'(2) : AW'(8));
    end

    assign w_acc_rd = r_acc[w_bx[AIW-1:0]];

    // Per-channel accumulate and rounded average.
    always_comb begin
        logic [AW-1:0] v_px, v_a, v_sum;
        w_acc_wr = '0;
        w_avg_px = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            v_px  = AW'(bus.i_data[c*DW +: DW]);
            v_a   = w_acc_rd[c*AW +: AW];
            v_sum = v_a + v_px + w_rnd;
            w_acc_wr[c*AW +: AW] = w_first ? v_px : (v_a + v_px);
            if (w_s == 2'd0) w_avg_px[c*DW +: DW] = bus.i_data[c*DW +: DW];
            else             w_avg_px[c*DW +: DW] = DW'(v_sum >> {w_s, 1'b0});
        end
    end

    // Accumulators need no reset: the first pixel of every block overwrites its column entry.
    always_ff @(posedge clk) begin
        if (w_beat && w_avg) r_acc[w_bx[AIW-1:0]] <= w_acc_wr;
    end

    // Next-state and raster counters.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_latch     = 1'b0;
        if (w_beat) begin
            if (w_end_x) begin
                w_x_nxt = '0;
                if (w_end_y) w_y_nxt = '0;
                else         w_y_nxt = r_y + 16'd1;
            end else begin
                w_x_nxt = r_x + XW'(1);
            end
            unique case (r_state)
                IDLE: begin
                    w_latch = 1'b1;
                    if (!(w_end_x && w_end_y)) w_state_nxt = RUN;
                end
                RUN: begin
                    if (w_end_x && w_end_y) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_s     <= '0;
            r_avg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            if (w_latch) begin
                r_w   <= w_w;
                r_h   <= w_h;
                r_s   <= w_s;
                r_avg <= w_avg;
            end
        end
    end

    // Single output register; a new emit may replace a draining pixel on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
            r_o_data  <= '0;
        end else if (w_beat && w_emit) begin
            r_o_valid <= 1'b1;
            r_o_last  <= w_final_blk;
            r_o_data  <= w_avg ? w_avg_px : bus.i_data;
        end else if (bus.o_ready) begin
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_downsample_2d.sv
// Randomized bench for downsample_2d: a block-level reference model fills an expectation queue
// that one monitor process compares against every consumed output pixel.
module tb_downsample_2d;
    localparam int unsigned DW    = 8;
    localparam int unsigned CH    = 3;
    localparam int unsigned MAX_W = 64;
    localparam int unsigned PW    = CH * DW;
    localparam int unsigned XW    = $clog2(MAX_W) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [XW-1:0] cfg_w = '0;
    logic [15:0]   cfg_h = '0;
    logic [1:0]    cfg_shift = '0;
    logic          cfg_avg = 1'b0;

    downsample_2d_if #(.DW(DW), .CH(CH)) bus ();

    downsample_2d #(.DW(DW), .CH(CH), .MAX_W(MAX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_w     (cfg_w),
        .cfg_h     (cfg_h),
        .cfg_shift (cfg_shift),
        .cfg_avg   (cfg_avg),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            rdy_rand = 0;
    logic [PW-1:0] exp_data[$];
    logic          exp_last[$];
    logic [PW-1:0] frame[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // kind 0: pixel index, kind 1: constant k, kind 2: random
    task automatic gen_frame(input int w, input int h, input int kind, input logic [DW-1:0] k);
        logic [PW-1:0] p;
        frame.delete();
        for (int i = 0; i < w * h; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (kind == 0)      p[c*DW +: DW] = DW'(i);
                else if (kind == 1) p[c*DW +: DW] = k;
                else                p[c*DW +: DW] = DW'($urandom);
            end
            frame.push_back(p);
        end
    endtask

    // Expected output of one frame, block by block in raster order.
    task automatic model_frame(input int w, input int h, input int sh, input bit avg);
        int s, f, nbw, nbh, sum, r;
        logic [PW-1:0] p, o;
        s   = (sh > 2) ? 2 : sh;
        f   = 1 << s;
        nbw = w / f;
        nbh = h / f;
        r   = (s == 0) ? 0 : (1 << (2 * s - 1));
        for (int by = 0; by < nbh; by++) begin
            for (int bx = 0; bx < nbw; bx++) begin
                o = '0;
                for (int c = 0; c < CH; c++) begin
                    if (avg) begin
                        sum = 0;
                        for (int dy = 0; dy < f; dy++)
                            for (int dx = 0; dx < f; dx++) begin
                                p = frame[(by * f + dy) * w + bx * f + dx];
                                sum += int'(p[c*DW +: DW]);
                            end
                        o[c*DW +: DW] = DW'((sum + r) / (f * f));
                    end else begin
                        p = frame[(by * f) * w + bx * f];
                        o[c*DW +: DW] = p[c*DW +: DW];
                    end
                end
                exp_data.push_back(o);
                exp_last.push_back((by == nbh - 1) && (bx == nbw - 1));
            end
        end
    endtask

    task automatic idle_cycle();
        bus.i_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [PW-1:0] px);
        bit acc;
        acc = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = px;
        for (int t = 0; t < 1000 && !acc; t++) begin
            @(negedge clk);
            acc = bus.i_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: i_ready stayed 0, required 1 within 1000 cycles");
        end
    endtask

    task automatic send_frame(input int w, input int h, input int sh, input bit avg, input bit gaps);
        cfg_w     = XW'(w);
        cfg_h     = 16'(h);
        cfg_shift = 2'(sh);
        cfg_avg   = avg;
        for (int i = 0; i < frame.size(); i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) idle_cycle();
            send_beat(frame[i]);
            if (i == 0) begin
                cfg_w     = XW'($urandom_range(1, MAX_W));
                cfg_h     = 16'($urandom_range(1, 9));
                cfg_shift = 2'($urandom);
                cfg_avg   = 1'($urandom);
            end
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input int sh, input bit avg,
                             input int kind, input logic [DW-1:0] k, input bit gaps);
        gen_frame(w, h, kind, k);
        model_frame(w, h, sh, avg);
        send_frame(w, h, sh, avg, gaps);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 500 && exp_data.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_remaining", 64'(exp_data.size()), 64'd0);
    endtask

    // Output sink with random backpressure.
    initial begin
        bus.o_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.o_ready = (rdy_rand != 0) ? 1'($urandom) : 1'b1;
        end
    end

    // Compare process: checks consumed outputs and stall behaviour every cycle.
    initial begin
        bit            prev_stall;
        logic [PW-1:0] prev_data;
        logic [PW-1:0] ed;
        logic          el;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_o_valid", 64'(bus.o_valid), 64'd1);
                    chk("stall_o_data", 64'(bus.o_data), 64'(prev_data));
                end
                if (bus.o_valid && !bus.o_ready) chk("stall_i_ready", 64'(bus.i_ready), 64'd0);
                if (bus.o_valid && bus.o_ready) begin
                    if (exp_data.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got data %0h, required no output", bus.o_data);
                    end else begin
                        ed = exp_data.pop_front();
                        el = exp_last.pop_front();
                        chk("out_data", 64'(bus.o_data), 64'(ed));
                        chk("out_last", 64'(bus.o_last), 64'(el));
                    end
                end
                prev_stall = bus.o_valid && !bus.o_ready;
                prev_data  = bus.o_data;
            end
        end
    end

    initial begin
        logic [PW-1:0] e;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_o_last", 64'(bus.o_last), 64'd0);
        chk("rst_o_data", 64'(bus.o_data), 64'd0);
        chk("rst_i_ready", 64'(bus.i_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 4x4 F=2 decimate, pixels 0..15
        gen_frame(4, 4, 0, 8'd0);
        model_frame(4, 4, 1, 1'b0);
        chk("pin_dec_n", 64'(exp_data.size()), 64'd4);
        e = exp_data[0]; chk("pin_dec_0", 64'(e[DW-1:0]), 64'd0);
        e = exp_data[1]; chk("pin_dec_1", 64'(e[DW-1:0]), 64'd2);
        e = exp_data[2]; chk("pin_dec_2", 64'(e[DW-1:0]), 64'd8);
        e = exp_data[3]; chk("pin_dec_3", 64'(e[DW-1:0]), 64'd10);
        chk("pin_dec_last2", 64'(exp_last[2]), 64'd0);
        chk("pin_dec_last3", 64'(exp_last[3]), 64'd1);
        send_frame(4, 4, 1, 1'b0, 1'b0);
        wait_drain();

        // 4x4 F=2 average, pixels 0..15
        gen_frame(4, 4, 0, 8'd0);
        model_frame(4, 4, 1, 1'b1);
        e = exp_data[0]; chk("pin_avg_0", 64'(e[DW-1:0]), 64'd3);
        e = exp_data[1]; chk("pin_avg_1", 64'(e[DW-1:0]), 64'd5);
        e = exp_data[2]; chk("pin_avg_2", 64'(e[DW-1:0]), 64'd11);
        e = exp_data[3]; chk("pin_avg_3", 64'(e[DW-1:0]), 64'd13);
        send_frame(4, 4, 1, 1'b1, 1'b0);
        wait_drain();

        // 2x2 F=2 average of all 255
        gen_frame(2, 2, 1, 8'd255);
        model_frame(2, 2, 1, 1'b1);
        e = exp_data[0]; chk("pin_avg_255", 64'(e), 64'hFFFFFF);
        send_frame(2, 2, 1, 1'b1, 1'b0);
        wait_drain();

        // 5x5 F=4 average of all 7: only one complete block
        gen_frame(5, 5, 1, 8'd7);
        model_frame(5, 5, 2, 1'b1);
        chk("pin_5x5_n", 64'(exp_data.size()), 64'd1);
        e = exp_data[0]; chk("pin_5x5_val", 64'(e), 64'h070707);
        chk("pin_5x5_last", 64'(exp_last[0]), 64'd1);
        send_frame(5, 5, 2, 1'b1, 1'b0);
        wait_drain();

        // Random backpressure, random RGB pixels
        rdy_rand = 1;
        run_frame(8, 8, 1, 1'b1, 2, 8'd0, 1'b0);
        run_frame(8, 8, 1, 1'b0, 2, 8'd0, 1'b1);
        wait_drain();

        // Reset mid-frame after 6 beats, then a full F=1 frame
        rdy_rand = 0;
        gen_frame(8, 8, 2, 8'd0);
        exp_data.push_back(frame[0]); exp_last.push_back(1'b0);
        exp_data.push_back(frame[2]); exp_last.push_back(1'b0);
        exp_data.push_back(frame[4]); exp_last.push_back(1'b0);
        cfg_w = XW'(8); cfg_h = 16'd8; cfg_shift = 2'd1; cfg_avg = 1'b0;
        for (int i = 0; i < 6; i++) send_beat(frame[i]);
        bus.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_drain", 64'(exp_data.size()), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("midrst_i_ready", 64'(bus.i_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_frame(8, 8, 0, 1'b0, 2, 8'd0, 1'b0);
        chk("f1_model_n", 64'(exp_data.size() > 0 ? 64 : 0), 64'd64);
        wait_drain();

        // Back-to-back frames with different configs
        rdy_rand = 1;
        run_frame(8, 8, 1, 1'b0, 2, 8'd0, 1'b0);
        run_frame(8, 8, 2, 1'b1, 2, 8'd0, 1'b0);
        wait_drain();

        // Random frames, shift 3 included, sometimes back-to-back
        for (int n = 0; n < 10; n++) begin
            run_frame(int'($urandom_range(1, 20)), int'($urandom_range(1, 10)),
                      int'($urandom_range(0, 3)), 1'($urandom), 2, 8'd0, 1'($urandom));
            if ($urandom_range(0, 1) == 0) wait_drain();
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
